// File: rtl/pc_sequencer.sv
// pc_sequencer: two-stage fetch/execute program counter sequencer with a
// 2-entry return-address stack.
//
// Each enabled clock edge latches the program-memory word (inst_in, addressed
// by pc_out) into ir_out while pc_out advances. The op of the instruction in
// ir_out (pc_op) steers the next pc_out. Taken control-flow ops replace the
// fetched word with a NOP bubble (ir_valid=0) for exactly one cycle.
//
// Optional feature macro: STACK_ERR_EN adds the sticky stack_err output.
//
// Parameters:
//   ADDR_WIDTH   program memory address width
//   RESET_VECTOR pc_out value while/after reset
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   en          advance enable; low holds all state
//   pc_op       op of the instruction in ir_out
//               (000 INC, 001 GOTO, 010 CALL, 011 RET, 100 SKIP, 101 PCWR)
//   target      destination for GOTO/CALL/PCWR
//   inst_in     program memory data at pc_out
//   pc_out      registered fetch address
//   ir_out      registered instruction being executed
//   ir_valid    ir_out holds a real instruction (0 = bubble)
//   stack_err   (STACK_ERR_EN only) sticky overflow/underflow flag
//   stack_full  stack count == 2
//   stack_empty stack count == 0

`ifndef INST_WIDTH
`define INST_WIDTH 12
`endif

module pc_sequencer #(
   parameter int                    ADDR_WIDTH   = 9,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 9'h1FF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [2:0]             pc_op,
   input  logic [ADDR_WIDTH-1:0]  target,
   input  logic [`INST_WIDTH-1:0] inst_in,
   output logic [ADDR_WIDTH-1:0]  pc_out,
   output logic [`INST_WIDTH-1:0] ir_out,
   output logic                   ir_valid,
`ifdef STACK_ERR_EN
   output logic                   stack_err,
`endif
   output logic                   stack_full,
   output logic                   stack_empty
);

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_GOTO = 3'b001;
   localparam logic [2:0] OP_CALL = 3'b010;
   localparam logic [2:0] OP_RET  = 3'b011;
   localparam logic [2:0] OP_SKIP = 3'b100;
   localparam logic [2:0] OP_PCWR = 3'b101;

   logic [ADDR_WIDTH-1:0]  stackTop;     // s0
   logic [ADDR_WIDTH-1:0]  stackBot;     // s1
   logic [1:0]             stackCnt;

   logic [2:0]             effOp;
   logic [ADDR_WIDTH-1:0]  pcInc;
   logic [ADDR_WIDTH-1:0]  pcNext;
   logic [`INST_WIDTH-1:0] irNext;
   logic                   validNext;
   logic                   doPush;
   logic                   doPop;

   // A bubble in ir_out carries no op, so the sequencer simply falls through.
   assign effOp = ir_valid ? pc_op : OP_INC;
   assign pcInc = pc_out + 1'b1;   // wraps naturally at 2^ADDR_WIDTH

   always_comb begin
      pcNext    = pcInc;
      irNext    = inst_in;
      validNext = 1'b1;
      doPush    = 1'b0;
      doPop     = 1'b0;
      case (effOp)
         OP_GOTO, OP_PCWR: begin
            pcNext    = target;
            irNext    = '0;
            validNext = 1'b0;
         end
         OP_CALL: begin
            // pc_out already points past the CALL: it is the return address.
            pcNext    = target;
            irNext    = '0;
            validNext = 1'b0;
            doPush    = 1'b1;
         end
         OP_RET: begin
            // Popping an empty stack still returns whatever s0 holds.
            pcNext    = stackTop;
            irNext    = '0;
            validNext = 1'b0;
            doPop     = 1'b1;
         end
         OP_SKIP: begin
            irNext    = '0;
            validNext = 1'b0;
         end
         default: ;   // INC and reserved codes
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out   <= RESET_VECTOR;
         ir_out   <= '0;
         ir_valid <= 1'b0;
         stackTop <= '0;
         stackBot <= '0;
         stackCnt <= 2'd0;
      end else if (en) begin
         pc_out   <= pcNext;
         ir_out   <= irNext;
         ir_valid <= validNext;
         if (doPush) begin
            // Full push shifts the oldest entry out of s1.
            stackBot <= stackTop;
            stackTop <= pc_out;
            if (stackCnt != 2'd2) stackCnt <= stackCnt + 2'd1;
         end else if (doPop) begin
            // s1 is left as-is, so repeated pops keep returning the same address.
            stackTop <= stackBot;
            if (stackCnt != 2'd0) stackCnt <= stackCnt - 2'd1;
         end
      end
   end

`ifdef STACK_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stack_err <= 1'b0;
      end else if (en && ((doPush && stackCnt == 2'd2) || (doPop && stackCnt == 2'd0))) begin
         stack_err <= 1'b1;
      end
   end
`endif

   assign stack_full  = (stackCnt == 2'd2);
   assign stack_empty = (stackCnt == 2'd0);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: ADDR_WIDTH, default 9, program memory address width (512 words).
REQ-002 Parameter: RESET_VECTOR, default 9'h1FF, PC value loaded on reset.
REQ-003 Instruction width SHALL be the codebase macro `INST_WIDTH` (12).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: en  input  1  advance enable; low = hold all state.
REQ-007 Port: pc_op  input  3  op of the instruction in ir_out: 000 INC, 001 GOTO, 010 CALL, 011 RET, 100 SKIP, 101 PCWR; 110/111 reserved.
REQ-008 Port: target  input  ADDR_WIDTH  destination for GOTO, CALL, PCWR.
REQ-009 Port: inst_in  input  `INST_WIDTH  combinational program memory data for pc_out.
REQ-010 Port: pc_out  output  ADDR_WIDTH  registered fetch address to program memory.
REQ-011 Port: ir_out  output  `INST_WIDTH  registered instruction being executed.
REQ-012 Port: ir_valid  output  1  ir_out is a real instruction (0 = flush bubble).
REQ-013 Port: stack_full / stack_empty  output  1 each  stack count == 2 / == 0.

Function
REQ-014 Two-stage fetch/execute: each enabled edge SHALL latch inst_in into ir_out while pc_out advances.
REQ-015 Effective op SHALL be pc_op when ir_valid=1, else INC; reserved codes SHALL act as INC.
REQ-016 INC: pc_out <= pc_out+1 modulo 2^ADDR_WIDTH (1FF wraps to 000); ir_out <= inst_in, ir_valid <= 1.
REQ-017 GOTO: pc_out <= target; flush.
REQ-018 CALL: push pc_out (return address) then pc_out <= target; flush.
REQ-019 RET: pc_out <= top of stack, pop; flush.
REQ-020 SKIP: pc_out <= pc_out+1 (wrapping); flush.
REQ-021 PCWR: pc_out <= target; flush; stack untouched.
REQ-022 Flush: ir_out <= 12'h000 (NOP), ir_valid <= 0; fetched inst_in discarded; exactly one bubble cycle per flushing op.
REQ-023 Stack: 2-entry shift register s0 (top), s1, plus count 0..2.
REQ-024 Push: s1 <= s0, s0 <= value, count saturates at 2; push when full SHALL discard old s1.
REQ-025 Pop: returns s0, s0 <= s1, s1 unchanged, count saturates at 0; pop when empty SHALL return current s0.
REQ-026 en=0: pc_out, ir_out, ir_valid, stack, count SHALL hold; pc_op ignored.
REQ-027 Fetch-to-execute latency: 1 cycle; taken branch target executes 2 cycles after branch executes.

Reset
REQ-028 On rst asserted, immediately: pc_out=RESET_VECTOR, ir_out=12'h000, ir_valid=0, s0=s1=0, count=0 (stack_empty=1, stack_full=0).
REQ-029 Reset mid-operation SHALL abandon pending branch/flush; first enabled edge after release fetches RESET_VECTOR.

Configuration
REQ-030 Macro STACK_ERR_EN defined: extra output port stack_err (1 bit), sticky, set on push when full or pop when empty, cleared only by rst.
REQ-031 STACK_ERR_EN undefined: stack_err port absent; all other behaviour identical.

Verification
REQ-032 Reset release, en=1, all INC -> pc_out 1FF, 000, 001; ir_valid 0 then 1; ir_out follows memory at prior pc.
REQ-033 GOTO target=0x040 at pc_out=0x012 -> next pc_out 0x040, one cycle ir_valid=0/ir_out=000, then word at 0x040 executes.
REQ-034 CALL 0x080 at pc_out=0x021, then RET -> stack_empty 0, pc_out returns to 0x021, stack_empty 1, two bubbles total.
REQ-035 Three nested CALLs from returns 0x010, 0x020, 0x030 -> three RETs yield 0x030, 0x020, 0x020; stack_err=1 with STACK_ERR_EN.
REQ-036 SKIP at pc_out=0x1FF -> pc_out 0x000, fetched word at 0x1FF discarded (ir_valid=0).
REQ-037 en=0 for 3 cycles with pc_op=GOTO, then rst pulse mid-branch -> state frozen during stall, pc_out=1FF after reset.
